// File: rtl/job_input_arbiter.sv
// job_input_arbiter: job-granular round-robin share of the hash_engine input, with an in-order tag FIFO of completed job owners (JOB_ARB_BEAT_CNT_EN adds per-job beat counts)
`ifndef HASH_ISSUE_WIDTH
`define HASH_ISSUE_WIDTH 8
`endif

module job_input_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int CH_ID_W   = 2,
    parameter int DATA_W    = `HASH_ISSUE_WIDTH * 8,
    parameter int TAG_DEPTH = 8
`ifdef JOB_ARB_BEAT_CNT_EN
    , parameter int BEAT_CNT_W = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_valid,
    output logic [NUM_CH-1:0]          ch_ready,
    input  logic [NUM_CH-1:0]          ch_delim,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic                       e_valid,
    input  logic                       e_ready,
    output logic                       e_delim,
    output logic [DATA_W-1:0]          e_data,
    output logic                       tag_valid,
    input  logic                       tag_ready,
    output logic [CH_ID_W-1:0]         tag_id,
`ifdef JOB_ARB_BEAT_CNT_EN
    output logic [BEAT_CNT_W-1:0]      tag_beats,
`endif
    output logic                       busy,
    output logic [CH_ID_W-1:0]         cur_ch,
    output logic [$clog2(TAG_DEPTH):0] tag_count
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q;
    logic [CH_ID_W-1:0] cur_ch_q, rr_q, win, idx;
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CH_ID_W-1:0] id_mem [TAG_DEPTH];
    logic               grant, accept, push, pop;

    // Round-robin pick: scanning offsets high to low leaves the nearest requester at or above rr_q
    always_comb begin
        win = cur_ch_q;
        idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = CH_ID_W'((int'(rr_q) + k) % NUM_CH);
            if (ch_valid[idx]) win = idx;
        end
    end

    // Zero-latency pass-through of the granted channel; a grant needs a free tag slot for its job
    always_comb begin
        busy      = state_q == BUSY;
        e_valid   = busy & ch_valid[cur_ch_q];
        e_delim   = busy & ch_delim[cur_ch_q];
        e_data    = busy ? DATA_W'(ch_data >> (int'(cur_ch_q) * DATA_W)) : '0;
        ch_ready  = busy ? NUM_CH'(e_ready) << cur_ch_q : '0;
        accept    = e_valid & e_ready;
        push      = accept & e_delim;
        tag_valid = cnt_q != '0;
        pop       = tag_valid & tag_ready;
        grant     = !busy && |ch_valid && cnt_q < CNT_W'(TAG_DEPTH);
    end

    // Job-level FSM: the grant is held until the delim beat of the job is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_ch_q <= '0;
            rr_q     <= '0;
        end else if (grant) begin
            state_q  <= BUSY;
            cur_ch_q <= win;
            rr_q     <= (win == CH_ID_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
        end else if (push) begin
            state_q  <= IDLE;
        end
    end

    // Tag FIFO pointers and occupancy; a same-cycle push and pop leaves the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Tag storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (push) id_mem[wr_q] <= cur_ch_q;
    end

    assign tag_id    = id_mem[rd_q];
    assign tag_count = cnt_q;
    assign cur_ch    = cur_ch_q;

`ifdef JOB_ARB_BEAT_CNT_EN
    logic [BEAT_CNT_W-1:0] beat_q, beat_inc;
    logic [BEAT_CNT_W-1:0] beat_mem [TAG_DEPTH];

    assign beat_inc = (&beat_q) ? beat_q : beat_q + 1'b1;

    // Saturating count of accepted beats in the current job, restarted at each grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) beat_q <= '0;
        else if (grant) beat_q <= '0;
        else if (accept) beat_q <= beat_inc;
    end

    // The pushed count includes the delim beat being accepted in the push cycle
    always_ff @(posedge clk) begin
        if (push) beat_mem[wr_q] <= beat_inc;
    end

    assign tag_beats = beat_mem[rd_q];
`endif
endmodule

// File: tb/tb_job_input_arbiter.sv
// tb_job_input_arbiter: directed checks of job arbitration, backpressure, tag FIFO limits and async reset
module tb_job_input_arbiter;
    localparam int NC = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] ch_valid, ch_ready, ch_delim;
    logic [NC*DW-1:0] ch_data;
    logic          e_valid, e_ready, e_delim;
    logic [DW-1:0] e_data;
    logic          tag_valid, tag_ready;
    logic [1:0]    tag_id, cur_ch;
    logic          busy;
    logic [3:0]    tag_count;
`ifdef JOB_ARB_BEAT_CNT_EN
    logic [15:0]   tag_beats;
`endif

    int checks = 0;
    int errors = 0;
    int len [NC];
    int left [NC];
    int idx [NC];
    int bad_rdy;
    logic [7:0]  acc_q [$];
    logic [1:0]  pop_q [$];
    logic [63:0] busy_tr, ev_tr;

    job_input_arbiter #(.NUM_CH(NC), .CH_ID_W(2), .DATA_W(DW), .TAG_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_delim(ch_delim), .ch_data(ch_data),
        .e_valid(e_valid), .e_ready(e_ready), .e_delim(e_delim), .e_data(e_data),
        .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_id(tag_id),
`ifdef JOB_ARB_BEAT_CNT_EN
        .tag_beats(tag_beats),
`endif
        .busy(busy), .cur_ch(cur_ch), .tag_count(tag_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Channel sources advance on their own handshakes; accepted beats and pops are logged
    task automatic run(input int n, input logic [63:0] rdy, input logic [63:0] trd);
        for (int c = 0; c < n; c++) begin
            e_ready   = rdy[c];
            tag_ready = trd[c];
            for (int i = 0; i < NC; i++) begin
                ch_valid[i] = left[i] > 0;
                ch_delim[i] = idx[i] == len[i] - 1;
                ch_data[i*DW +: DW] = 8'(i * 16 + idx[i]);
            end
            #1;
            busy_tr[c] = busy;
            ev_tr[c]   = e_valid;
            if (ch_ready !== (busy ? 4'(e_ready) << cur_ch : 4'b0)) bad_rdy++;
            if (e_valid && e_ready) acc_q.push_back(e_data);
            if (tag_valid && tag_ready) pop_q.push_back(tag_id);
            for (int i = 0; i < NC; i++) begin
                if (ch_valid[i] && ch_ready[i]) begin
                    idx[i]++;
                    if (idx[i] == len[i]) begin
                        idx[i] = 0;
                        left[i]--;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        tag_ready = 1'b0;
    endtask

    task automatic do_reset(input string t);
        rst = 1'b1;
        #1;
        check({t, ".busy"}, 32'(busy), 0);
        check({t, ".cur_ch"}, 32'(cur_ch), 0);
        check({t, ".tag_count"}, 32'(tag_count), 0);
        check({t, ".tag_valid"}, 32'(tag_valid), 0);
        check({t, ".e_valid"}, 32'(e_valid), 0);
        check({t, ".ch_ready"}, 32'(ch_ready), 0);
        check({t, ".e_data"}, 32'(e_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NC; i++) begin
            len[i]  = 1;
            left[i] = 0;
            idx[i]  = 0;
        end
        acc_q.delete();
        pop_q.delete();
        bad_rdy = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_rr [10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h00, 8'h01};
        logic [1:0] exp_pop [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        ch_valid = '0; ch_delim = '0; ch_data = '0; e_ready = 1'b0; tag_ready = 1'b0;
        clear_src();
        @(posedge clk);
        #1;
        do_reset("rst0");

        // single 3-beat job on ch0
        len[0] = 3; left[0] = 1;
        run(5, '1, '0);
        check("s1.busy_trace", 32'(busy_tr[4:0]), 32'b01110);
        check("s1.evalid_trace", 32'(ev_tr[4:0]), 32'b01110);
        check("s1.beats", acc_q.size(), 3);
        check("s1.beat0", 32'(acc_q[0]), 8'h00);
        check("s1.beat2", 32'(acc_q[2]), 8'h02);
        check("s1.tag_count", 32'(tag_count), 1);
        check("s1.tag_id", 32'(tag_id), 0);
`ifdef JOB_ARB_BEAT_CNT_EN
        check("s1.tag_beats", 32'(tag_beats), 3);
`endif
        run(1, '1, '1);
        check("s1.pop_id", 32'(pop_q[0]), 0);
        check("s1.tag_count_after_pop", 32'(tag_count), 0);

        // all four channels, 2-beat jobs, ch0 twice, from rr_ptr=0
        clear_src();
        do_reset("rst1");
        for (int i = 0; i < NC; i++) begin
            len[i] = 2; left[i] = 1;
        end
        left[0] = 2;
        run(16, '1, '0);
        check("s2.busy_trace", 32'(busy_tr[15:0]), 32'h6DB6);
        check("s2.beats", acc_q.size(), 10);
        for (int k = 0; k < 10; k++) check($sformatf("s2.beat%0d", k), 32'(acc_q[k]), 32'(exp_rr[k]));
        check("s2.tag_count", 32'(tag_count), 5);
        check("s2.bad_ready", bad_rdy, 0);
        run(5, '1, '1);
        for (int k = 0; k < 5; k++) check($sformatf("s2.pop%0d", k), 32'(pop_q[k]), 32'(exp_pop[k]));
        check("s2.tag_count_empty", 32'(tag_count), 0);

        // ch2 job under e_ready 1,0,1,0 backpressure
        clear_src();
        len[2] = 3; left[2] = 1;
        run(7, 64'h6B, '0);
        check("s3.busy_trace", 32'(busy_tr[6:0]), 32'h3E);
        check("s3.beats", acc_q.size(), 3);
        check("s3.beat0", 32'(acc_q[0]), 8'h20);
        check("s3.beat1", 32'(acc_q[1]), 8'h21);
        check("s3.beat2", 32'(acc_q[2]), 8'h22);
        check("s3.bad_ready", bad_rdy, 0);
        run(1, '1, '1);
        check("s3.pop_id", 32'(pop_q[0]), 2);

        // tag FIFO full blocks a new grant until one pop
        clear_src();
        do_reset("rst2");
        left[0] = 8;
        run(17, '1, '0);
        check("s4.tag_count_full", 32'(tag_count), 8);
`ifdef JOB_ARB_BEAT_CNT_EN
        check("s4.tag_beats", 32'(tag_beats), 1);
`endif
        left[1] = 1;
        run(3, '1, '0);
        check("s4.no_grant", 32'(busy_tr[2:0]), 0);
        run(1, '1, '1);
        check("s4.count_after_pop", 32'(tag_count), 7);
        check("s4.busy_after_pop", 32'(busy), 0);
        acc_q.delete();
        run(3, '1, '0);
        check("s4.grant_trace", 32'(busy_tr[2:0]), 32'b010);
        check("s4.ch1_beat", 32'(acc_q[0]), 8'h10);
        check("s4.tag_count_refull", 32'(tag_count), 8);
        pop_q.delete();
        run(8, '1, '1);
        check("s4.pops", pop_q.size(), 8);
        check("s4.pop_first", 32'(pop_q[0]), 0);
        check("s4.pop_last", 32'(pop_q[7]), 1);

        // push and pop on the same delim cycle with three tags queued
        clear_src();
        do_reset("rst3");
        for (int i = 1; i < NC; i++) left[i] = 1;
        run(7, '1, '0);
        check("s5.tag_count_pre", 32'(tag_count), 3);
        len[0] = 2; left[0] = 1;
        run(4, '1, 64'b0100);
        check("s5.tag_count_same", 32'(tag_count), 3);
        check("s5.pop_oldest", 32'(pop_q[0]), 1);
        run(3, '1, '1);
        check("s5.pop1", 32'(pop_q[1]), 2);
        check("s5.pop2", 32'(pop_q[2]), 3);
        check("s5.pop3", 32'(pop_q[3]), 0);

        // reset mid-job on ch3 after two of five beats, then the job is resent
        clear_src();
        len[3] = 5; left[3] = 1;
        run(3, '1, '0);
        check("s6.busy_mid", 32'(busy), 1);
        check("s6.accepted_mid", acc_q.size(), 2);
        do_reset("s6.rst");
        idx[3] = 0;
        acc_q.delete();
        run(7, '1, '0);
        check("s6.beats", acc_q.size(), 5);
        check("s6.beat0", 32'(acc_q[0]), 8'h30);
        check("s6.beat4", 32'(acc_q[4]), 8'h34);
        check("s6.tag_id", 32'(tag_id), 3);
        check("s6.tag_count", 32'(tag_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
